pattern_scan_ctrl: RTL and testbench

Controller and scheduler for a programmable serial pattern detector. It accepts parallel words over a valid/ready handshake and shifts them MSB-first, one bit per clock, through an internal overlapping pattern matcher, which is a generalised Mealy sequence detector. It counts the matches per word and returns the result over a second valid/ready handshake. It sits between a word-oriented producer and a result consumer. Pattern configuration is allowed only while the block is idle.

---
 rtl/pattern_scan_if.sv | 25 ++
 rtl/pattern_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_if.sv
// pattern_scan_if: word-in / result-out valid/ready bundle
// shared by the pattern scanner and its neighbours.
interface pattern_scan_if #(
  parameter int DW = 16,
  parameter int CW = 5
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_chain;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_count;
  logic          out_hit;
  logic          out_ready;

  modport master (
    output in_valid, in_data, in_chain, out_ready,
    input  in_ready, out_valid, out_count, out_hit
  );

  modport slave (
    input  in_valid, in_data, in_chain, out_ready,
    output in_ready, out_valid, out_count, out_hit
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: shifts words MSB-first through an
// overlapping Mealy pattern matcher and reports match counts.
module pattern_scan_ctrl #(
  parameter int DW = 16,
  parameter int PW = 6,
  parameter int CW = 5,
  parameter logic [PW-1:0] PAT_DEFAULT = 6'b101010
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_pat,
  pattern_scan_if.slave bus,
  output logic          busy,
  output logic          ser_bit,
  output logic          ser_en,
  output logic          det_pulse
);

  localparam int IW = $clog2(DW);
  localparam int LW = $clog2(PW + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] word;
  logic [IW-1:0] idx;
  logic [PW-1:0] pattern;
  logic [PW-1:0] hist;
  logic [PW-1:0] hist_n;
  logic [LW-1:0] hist_len;
  logic [CW-1:0] count;
  logic          accept;
  logic          last;

  // word register shifts left, so the MSB is always the live bit
  assign ser_en    = (state == SHIFT);
  assign ser_bit   = ser_en & word[DW-1];
  assign hist_n    = {hist[PW-2:0], ser_bit};
  assign det_pulse = ser_en
                   && (hist_len >= LW'(PW - 1))
                   && (hist_n == pattern);

  // a pattern write in the same cycle blocks acceptance
  assign accept = (state == IDLE) && bus.in_valid && !cfg_we;
  assign last   = (idx == IW'(DW - 1));

  // count register doubles as the held result
  assign bus.out_count = count;
  assign bus.out_hit   = |count;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state and handshake outputs
  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        busy         = 1'b0;
        bus.in_ready = !cfg_we;
        if (accept) state_n = SHIFT;
      end
      SHIFT: begin
        if (last) state_n = REPORT;
      end
      REPORT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // pattern, history, word shifter and match counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern  <= PAT_DEFAULT;
      hist     <= '0;
      hist_len <= '0;
      idx      <= '0;
      count    <= '0;
      word     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            pattern  <= cfg_pat;
            hist     <= '0;
            hist_len <= '0;
          end else if (bus.in_valid) begin
            word  <= bus.in_data;
            idx   <= '0;
            count <= '0;
            if (!bus.in_chain) begin
              hist     <= '0;
              hist_len <= '0;
            end
          end
        end
        SHIFT: begin
          word <= {word[DW-2:0], 1'b0};
          idx  <= idx + 1'b1;
          hist <= hist_n;
          if (hist_len != LW'(PW)) hist_len <= hist_len + 1'b1;
          count <= count + CW'(det_pulse);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed and random scenarios checked
// against a queue-based model of the overlapping matcher.
module tb_pattern_scan_ctrl;
  localparam int DW = 16;
  localparam int PW = 6;
  localparam int CW = 5;
  localparam logic [PW-1:0] PDEF = 6'b101010;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [PW-1:0] cfg_pat;
  logic          busy, ser_bit, ser_en, det_pulse;

  pattern_scan_if #(.DW(DW), .CW(CW)) bus ();

  pattern_scan_ctrl #(
    .DW(DW), .PW(PW), .CW(CW), .PAT_DEFAULT(PDEF)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
    .bus(bus), .busy(busy), .ser_bit(ser_bit),
    .ser_en(ser_en), .det_pulse(det_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [PW-1:0] m_pat;
  bit            m_hist[$];

  function automatic void m_reset();
    m_pat = PDEF;
    m_hist.delete();
  endfunction

  function automatic void m_cfg(input logic [PW-1:0] p);
    m_pat = p;
    m_hist.delete();
  endfunction

  // bit k of mask = match on the k-th bit sent (MSB first)
  function automatic void model_word(input logic [DW-1:0] w,
    input logic chain, output logic [DW-1:0] mask, output int cnt);
    bit ok;
    mask = '0;
    cnt = 0;
    if (!chain) m_hist.delete();
    for (int k = 0; k < DW; k++) begin
      m_hist.push_back(w[DW-1-k]);
      if (m_hist.size() > PW) void'(m_hist.pop_front());
      if (m_hist.size() == PW) begin
        ok = 1;
        for (int j = 0; j < PW; j++)
          if (m_hist[j] != m_pat[PW-1-j]) ok = 0;
        if (ok) begin
          mask[k] = 1'b1;
          cnt++;
        end
      end
    end
  endfunction

  task automatic start_word(input logic [DW-1:0] w,
    input logic chain, output bit to);
    int n;
    n = 0;
    to = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = w;
    bus.in_chain = chain;
    #1;
    while (!bus.in_ready) begin
      n++;
      if (n > 50) begin
        to = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!to) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(output logic [DW-1:0] det,
    output logic [DW-1:0] ser, output int lat);
    lat = 0;
    det = '0;
    ser = '0;
    forever begin
      @(negedge clk);
      if (bus.out_valid || lat > 3 * DW) break;
      if (lat < DW) begin
        det[lat] = det_pulse;
        ser[lat] = ser_bit;
      end
      lat++;
    end
  endtask

  task automatic release_result(output int cnt, output logic hit);
    cnt = int'(bus.out_count);
    hit = bus.out_hit;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_word(input logic [DW-1:0] w, input logic chain,
    input int hold, output logic [DW-1:0] det,
    output logic [DW-1:0] ser, output int lat,
    output int cnt, output logic hit);
    bit to;
    start_word(w, chain, to);
    if (to) begin
      det = '0; ser = '0; lat = -1; cnt = -1; hit = 1'b0;
      return;
    end
    collect(det, ser, lat);
    if (!bus.out_valid) begin
      cnt = -1;
      hit = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    release_result(cnt, hit);
  endtask

  task automatic test_reset();
    logic [CW+6:0] got;
    @(negedge clk);
    got = {bus.out_valid, busy, ser_en, det_pulse,
           ser_bit, bus.out_hit, bus.out_count};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h expected 0", got);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_default_aaaa();
    logic [DW-1:0] det, ser, emask;
    int lat, cnt, ecnt;
    logic hit;
    model_word(16'hAAAA, 1'b0, emask, ecnt);
    do_word(16'hAAAA, 1'b0, 0, det, ser, lat, cnt, hit);
    n_checks++;
    if (lat !== DW) begin
      n_fail++;
      $display("FAIL aaaa_latency: got %0d expected %0d", lat, DW);
    end
    n_checks++;
    if (det !== 16'hAAA0 || det !== emask) begin
      n_fail++;
      $display("FAIL aaaa_det: got %h expected %h", det, emask);
    end
    n_checks++;
    if (cnt !== 6 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL aaaa_count: got %0d/%b expected 6/1", cnt, hit);
    end
  endtask

  task automatic test_chain();
    logic [DW-1:0] det, ser, emask;
    int lat, cnt, ecnt;
    logic hit;
    for (int c = 1; c >= 0; c--) begin
      model_word(16'h0002, 1'b0, emask, ecnt);
      do_word(16'h0002, 1'b0, 0, det, ser, lat, cnt, hit);
      model_word(16'hA000, c[0], emask, ecnt);
      do_word(16'hA000, c[0], 0, det, ser, lat, cnt, hit);
      n_checks++;
      if (cnt !== ecnt || cnt !== c || hit !== c[0]) begin
        n_fail++;
        $display("FAIL chain%0d_count: got %0d/%b expected %0d",
                 c, cnt, hit, ecnt);
      end
      n_checks++;
      if (det !== emask) begin
        n_fail++;
        $display("FAIL chain%0d_det: got %h expected %h", c, det, emask);
      end
    end
  endtask

  task automatic test_cfg_priority();
    logic [DW-1:0] det, ser, emask;
    int lat, cnt, ecnt;
    logic hit;
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_pat = 6'b111111;
    bus.in_valid = 1'b1;
    bus.in_data = 16'hFFFF;
    bus.in_chain = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_in_ready: got %b expected 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_no_accept: busy got %b expected 0", busy);
    end
    m_cfg(6'b111111);
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_next_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_word(16'hFFFF, 1'b0, emask, ecnt);
    collect(det, ser, lat);
    release_result(cnt, hit);
    n_checks++;
    if (cnt !== 11 || cnt !== ecnt || det !== emask) begin
      n_fail++;
      $display("FAIL cfg_ffff: got %0d/%h expected %0d/%h",
               cnt, det, ecnt, emask);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] det, ser, emask;
    int lat, cnt, ecnt;
    logic hit;
    bit to;
    model_word(16'hFFF0, 1'b0, emask, ecnt);
    start_word(16'hFFF0, 1'b0, to);
    collect(det, ser, lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = DW'($urandom);
      cfg_we = 1'b1;
      cfg_pat = PDEF;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || int'(bus.out_count) !== ecnt
          || bus.out_hit !== (ecnt != 0) || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: v=%b c=%0d h=%b r=%b expected 1 %0d",
                 i, bus.out_valid, bus.out_count, bus.out_hit,
                 bus.in_ready, ecnt);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    cfg_we = 1'b0;
    release_result(cnt, hit);
    n_checks++;
    if (cnt !== 7 || cnt !== ecnt) begin
      n_fail++;
      $display("FAIL hold_release: got %0d expected %0d", cnt, ecnt);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drop: got %b expected 0", bus.out_valid);
    end
    model_word(16'hFFFF, 1'b0, emask, ecnt);
    do_word(16'hFFFF, 1'b0, 0, det, ser, lat, cnt, hit);
    n_checks++;
    if (cnt !== ecnt) begin
      n_fail++;
      $display("FAIL hold_pat_kept: got %0d expected %0d", cnt, ecnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] det, ser, emask;
    int lat, cnt, ecnt;
    logic hit;
    bit to;
    start_word(16'hAAAA, 1'b0, to);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || ser_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_abort: v=%b busy=%b en=%b expected 0",
               bus.out_valid, busy, ser_en);
    end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    model_word(16'hAAAA, 1'b1, emask, ecnt);
    do_word(16'hAAAA, 1'b1, 1, det, ser, lat, cnt, hit);
    n_checks++;
    if (cnt !== 6 || cnt !== ecnt || det !== emask) begin
      n_fail++;
      $display("FAIL midrst_next: got %0d/%h expected %0d/%h",
               cnt, det, ecnt, emask);
    end
  endtask

  task automatic test_zero();
    logic [DW-1:0] det, ser, emask;
    int lat, cnt, ecnt;
    logic hit;
    model_word(16'h0000, 1'b0, emask, ecnt);
    do_word(16'h0000, 1'b0, 0, det, ser, lat, cnt, hit);
    n_checks++;
    if (cnt !== 0 || hit !== 1'b0 || det !== '0) begin
      n_fail++;
      $display("FAIL zero: got %0d/%b/%h expected 0/0/0", cnt, hit, det);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] w, det, ser, emask, eser;
    logic [PW-1:0] p;
    logic ch, hit;
    int lat, cnt, ecnt;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(5) == 0) begin
        p = PW'($urandom);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_pat = p;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        m_cfg(p);
      end
      w = ($urandom_range(1) == 0) ? DW'($urandom)
                                   : {DW/2{2'($urandom)}};
      ch = 1'($urandom);
      for (int k = 0; k < DW; k++) eser[k] = w[DW-1-k];
      model_word(w, ch, emask, ecnt);
      do_word(w, ch, $urandom_range(3), det, ser, lat, cnt, hit);
      n_checks++;
      if (lat !== DW || ser !== eser || det !== emask
          || cnt !== ecnt || hit !== (ecnt != 0)) begin
        n_fail++;
        $display("FAIL rand_%0d: w=%h lat=%0d ser=%h det=%h cnt=%0d hit=%b expected lat=%0d ser=%h det=%h cnt=%0d",
                 i, w, lat, ser, det, cnt, hit, DW, eser, emask, ecnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[3];
    logic [DW-1:0] mk;
    int acc[3];
    int exp_q[$];
    int na, nr, cyc, c;
    na = 0; nr = 0; cyc = 0;
    for (int i = 0; i < 3; i++) w[i] = DW'($urandom);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_chain = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = w[0];
    while ((na < 3 || nr < 3) && cyc < 200) begin
      #1;
      if (bus.out_valid) begin
        n_checks++;
        if (nr >= exp_q.size() || int'(bus.out_count) !== exp_q[nr]) begin
          n_fail++;
          $display("FAIL b2b_count_%0d: got %0d", nr, bus.out_count);
        end
        nr++;
      end
      if (bus.in_valid && bus.in_ready) begin
        model_word(w[na], 1'b1, mk, c);
        exp_q.push_back(c);
        acc[na] = cyc;
        na++;
        @(posedge clk);
        #1;
        if (na < 3) bus.in_data = w[na];
        else bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (na != 3 || nr != 3) begin
      n_fail++;
      $display("FAIL b2b_done: accepts %0d results %0d expected 3 3",
               na, nr);
    end else begin
      n_checks++;
      if (acc[1] - acc[0] != DW + 2 || acc[2] - acc[1] != DW + 2) begin
        n_fail++;
        $display("FAIL b2b_period: got %0d %0d expected %0d",
                 acc[1] - acc[0], acc[2] - acc[1], DW + 2);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_pat = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_chain = 1'b0;
    bus.out_ready = 1'b0;
    m_reset();
    test_reset();
    test_default_aaaa();
    test_chain();
    test_cfg_priority();
    test_backpressure();
    test_reset_mid();
    test_zero();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
